// File: rtl/serial_mc_ctrl.sv
// Serial magnitude comparator: compares two WIDTH-bit unsigned operands one nibble per cycle, MSB nibble first.
// Latency: done pulses in the cycle after edge T+k; k = WIDTH/4, or the first unequal nibble index+1 with SERIAL_MC_EARLY_EXIT_EN.
// Backpressure: start is honoured only in IDLE and is ignored while busy; the caller re-presents start once busy drops.
// Optional feature macro: SERIAL_MC_EARLY_EXIT_EN (stop at the first unequal nibble).
module serial_mc_ctrl #(
   parameter int WIDTH = 16,
   localparam int NW = WIDTH / 4,
   localparam int IW = (NW > 1) ? $clog2(NW) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             a_gt_b,
   output logic             a_eq_b,
   output logic             a_lt_b,
   output logic [IW-1:0]    nib_idx
);

   typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, DONE = 2'd2} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IW-1:0]    r_idx;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;

   logic [WIDTH-1:0] w_sh_a;
   logic [WIDTH-1:0] w_sh_b;
   logic [3:0]       w_nib_a;
   logic [3:0]       w_nib_b;
   logic             w_last;
   logic             w_decided;

   // Shift the selected nibble to the top so one 4-bit slice serves every index.
   assign w_sh_a    = r_a << {r_idx, 2'b00};
   assign w_sh_b    = r_b << {r_idx, 2'b00};
   assign w_nib_a   = w_sh_a[WIDTH-1 -: 4];
   assign w_nib_b   = w_sh_b[WIDTH-1 -: 4];
   assign w_last    = (r_idx == IW'(NW - 1));
   assign w_decided = r_gt | r_lt;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic; DONE always lasts exactly one cycle.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: if (start) w_state_nxt = CMP;
         CMP: begin
`ifdef SERIAL_MC_EARLY_EXIT_EN
            if ((w_nib_a != w_nib_b) || w_last) w_state_nxt = DONE;
`else
            if (w_last) w_state_nxt = DONE;
`endif
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture, nibble walk and sticky result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_idx <= '0;
         r_gt  <= 1'b0;
         r_eq  <= 1'b0;
         r_lt  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_idx <= '0;
                  r_gt  <= 1'b0;
                  r_eq  <= 1'b0;
                  r_lt  <= 1'b0;
               end
            end
            CMP: begin
               // Only the first unequal nibble may set a flag.
               if (!w_decided) begin
                  if (w_nib_a > w_nib_b)      r_gt <= 1'b1;
                  else if (w_nib_a < w_nib_b) r_lt <= 1'b1;
                  else if (w_last)            r_eq <= 1'b1;
               end
`ifdef SERIAL_MC_EARLY_EXIT_EN
               if (!w_last && (w_nib_a == w_nib_b)) r_idx <= r_idx + IW'(1);
`else
               if (!w_last) r_idx <= r_idx + IW'(1);
`endif
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state != IDLE);
   assign done    = (r_state == DONE);
   assign a_gt_b  = r_gt;
   assign a_eq_b  = r_eq;
   assign a_lt_b  = r_lt;
   assign nib_idx = r_idx;

endmodule

// File: tb/tb_serial_mc_ctrl.sv
// Bench for serial_mc_ctrl at WIDTH=16; expectations come from a behavioural comparator model.
// Scoreboard entries are pushed at start acceptance and popped by the done monitor.
// Follows SERIAL_MC_EARLY_EXIT_EN if it is defined for the build.
module tb_serial_mc_ctrl;
   localparam int WIDTH = 16;
   localparam int NW    = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy, done, a_gt_b, a_eq_b, a_lt_b;
   logic [1:0]       nib_idx;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic gt;
      logic eq;
      logic lt;
      int   lat;
      int   idx;
      int   t0;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;

   serial_mc_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
      .a_lt_b(a_lt_b), .nib_idx(nib_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
      exp_t e;
      int   first;
      logic [WIDTH-1:0] ta, tb;
      first = -1;
      ta = va;
      tb = vb;
      for (int i = 0; i < NW; i++) begin
         if (first < 0 && ta[WIDTH-1-4*i -: 4] != tb[WIDTH-1-4*i -: 4]) first = i;
      end
      e.gt = (va > vb);
      e.eq = (va == vb);
      e.lt = (va < vb);
`ifdef SERIAL_MC_EARLY_EXIT_EN
      e.lat = (first < 0) ? NW : first + 1;
      e.idx = (first < 0) ? NW - 1 : first;
`else
      e.lat = NW;
      e.idx = NW - 1;
`endif
      e.t0 = 0;
      return e;
   endfunction

   // Done monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
         end else begin
            e = sb.pop_front();
            last_exp = e;
            checks++;
            if ({a_gt_b, a_eq_b, a_lt_b} !== {e.gt, e.eq, e.lt}) begin
               errors++;
               $display("FAIL flags: gt/eq/lt=%b%b%b, required %b%b%b", a_gt_b, a_eq_b, a_lt_b, e.gt, e.eq, e.lt);
            end
            checks++;
            if (cyc - e.t0 !== e.lat) begin
               errors++;
               $display("FAIL latency: k=%0d, required %0d", cyc - e.t0, e.lat);
            end
            checks++;
            if (int'(nib_idx) !== e.idx) begin
               errors++;
               $display("FAIL nib_idx_at_done: %0d, required %0d", nib_idx, e.idx);
            end
         end
      end
   end

   task automatic drive(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input bit push);
      exp_t e;
      @(negedge clk);
      a = va;
      b = vb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (push) begin
         e = model(va, vb);
         e.t0 = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL timeout: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, a_gt_b, a_eq_b, a_lt_b, nib_idx} !== 7'b0) begin
         errors++;
         $display("FAIL reset_state: busy/done/gt/eq/lt/idx=%b, required 0000000",
                  {busy, done, a_gt_b, a_eq_b, a_lt_b, nib_idx});
      end
      // Start in the very first cycle after reset is released.
      rst = 1'b0;
      start = 1'b1;
      a = 16'h1234;
      b = 16'h1234;
      @(posedge clk);
      #1;
      start = 1'b0;
      e = model(16'h1234, 16'h1234);
      e.t0 = cyc;
      sb.push_back(e);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || nib_idx !== 2'd0) begin
         errors++;
         $display("FAIL start_after_reset: busy=%b idx=%0d, required busy=1 idx=0", busy, nib_idx);
      end
      wait_done();
   endtask

   task automatic test_vectors();
      logic [WIDTH-1:0] va, vb;
      logic [WIDTH-1:0] tab_a [4] = '{16'h1234, 16'h9000, 16'h0005, 16'hABCD};
      logic [WIDTH-1:0] tab_b [4] = '{16'h1234, 16'h8FFF, 16'h0009, 16'hAB0D};
      for (int i = 0; i < 10; i++) begin
         if (i < 4) begin
            va = tab_a[i];
            vb = tab_b[i];
         end else begin
            va = WIDTH'($urandom);
            vb = ($urandom_range(0, 3) == 0) ? va : (va ^ (WIDTH'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3))));
         end
         drive(va, vb, 1'b1);
         wait_done();
         repeat (2) @(negedge clk);
         checks++;
         if ({a_gt_b, a_eq_b, a_lt_b} !== {last_exp.gt, last_exp.eq, last_exp.lt} || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold: a=%h b=%h gt/eq/lt=%b%b%b busy=%b, required %b%b%b busy=0", va, vb,
                     a_gt_b, a_eq_b, a_lt_b, busy, last_exp.gt, last_exp.eq, last_exp.lt);
         end
      end
   endtask

   task automatic test_ignore_start();
      drive(16'hF000, 16'h0000, 1'b1);
      @(negedge clk);
      @(negedge clk);
      a = 16'h0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      repeat (6) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || a_gt_b !== 1'b1) begin
         errors++;
         $display("FAIL ignore_start: busy=%b gt=%b, required busy=0 gt=1", busy, a_gt_b);
      end
   endtask

   task automatic test_reset_abort();
      drive(16'h0001, 16'h0002, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, a_gt_b, a_eq_b, a_lt_b, nib_idx} !== 7'b0) begin
         errors++;
         $display("FAIL reset_abort: busy/done/gt/eq/lt/idx=%b, required 0000000",
                  {busy, done, a_gt_b, a_eq_b, a_lt_b, nib_idx});
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   n;
      @(negedge clk);
      a = 16'hF000;
      b = 16'h0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      e = model(16'hF000, 16'h0000);
      e.t0 = cyc;
      sb.push_back(e);
      @(negedge clk);
      a = 16'h0001;
      b = 16'h0001;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first_done: done=%b, required 1", done);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle_gap: busy=%b, required 0", busy);
      end
      @(posedge clk);
      #1;
      e = model(16'h0001, 16'h0001);
      e.t0 = cyc;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, a_gt_b, a_eq_b, a_lt_b, nib_idx} !== 6'b100000) begin
         errors++;
         $display("FAIL b2b_clear: busy/gt/eq/lt/idx=%b, required 100000", {busy, a_gt_b, a_eq_b, a_lt_b, nib_idx});
      end
      wait_done();
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
